multiport_ram: RTL and testbench

- Parametrised successor to the single-port dummy data RAM used in core benches.
- Serves N_PORTS cores through the existing mem_read/mem_write/mem_atomic/mem_wait handshake.
- Adds round-robin arbitration, configurable wait-state latency, and per-port LR/SC reservations, so multicore atomics can be exercised before a real cache/interconnect exists.

---
 rtl/multiport_ram_pkg.sv | 34 +++
 rtl/multiport_ram_if.sv | 24 ++
 rtl/multiport_ram_rr_arbiter.sv | 32 +++
 rtl/multiport_ram.sv | 166 ++++++++++++++++
 tb/tb_multiport_ram.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/multiport_ram_pkg.sv
// Shared types and constants for the multi-port data RAM.
package multiport_ram_pkg;

  // Default wait cycles between grant and access.
  localparam int MEM_LAT = 1;

  // Store-conditional status words returned on mem_data_r.
  localparam int SC_OK   = 0;
  localparam int SC_FAIL = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_LR    = 2'd2,
    OP_SC    = 2'd3
  } op_t;

  // Read and write together count as a write; atomic turns them into SC/LR.
  function automatic op_t decode_op(input logic rd, input logic wr, input logic at);
    op_t op;
    if (wr) begin
      op = at ? OP_SC : OP_WRITE;
    end else begin
      op = (at && rd) ? OP_LR : OP_READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/multiport_ram_if.sv
// Bundled per-port core memory handshake (flattened across N_PORTS).
interface multiport_ram_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [N_PORTS*ADDR_W-1:0] mem_addr;
  logic [N_PORTS*DATA_W-1:0] mem_data_w;
  logic [N_PORTS-1:0]        mem_read;
  logic [N_PORTS-1:0]        mem_write;
  logic [N_PORTS-1:0]        mem_atomic;
  logic [N_PORTS*DATA_W-1:0] mem_data_r;
  logic [N_PORTS-1:0]        mem_wait;

  modport master (
    output mem_addr, mem_data_w, mem_read, mem_write, mem_atomic,
    input  mem_data_r, mem_wait
  );

  modport slave (
    input  mem_addr, mem_data_w, mem_read, mem_write, mem_atomic,
    output mem_data_r, mem_wait
  );
endinterface

// File: rtl/multiport_ram_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module multiport_ram_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // Scan the ports starting at ptr, wrapping, and take the first one asking.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = PTR_W'(j);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/multiport_ram.sv
// Multi-port word RAM with round-robin arbitration, wait states and LR/SC.
module multiport_ram
  import multiport_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int SIZE    = 1024,
  parameter int N_PORTS = 2,
  parameter int LATENCY = MEM_LAT
) (
  input logic             clk,
  input logic             rst_n,
  input logic             en,
  multiport_ram_if.slave  bus
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [N_PORTS-1:0]        req;
  logic [N_PORTS-1:0]        ack;
  logic [N_PORTS-1:0]        arb_grant;
  logic [PTR_W-1:0]          arb_idx;
  logic                      arb_valid;
  state_t                    state_r, state_n;
  logic [3:0]                cnt_r;
  logic [PTR_W-1:0]          rr_ptr_r;
  logic [PTR_W-1:0]          grant_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [DATA_W-1:0]         wdata_r;
  op_t                       op_r;
  logic [N_PORTS-1:0]        resv_valid_r;
  logic [ADDR_W-1:0]         resv_addr_r [N_PORTS];
  logic [DATA_W-1:0]         hold_r [N_PORTS];
  logic [DATA_W-1:0]         mem [SIZE];
  logic                      access, in_range, sc_hit, do_write;
  logic [DATA_W-1:0]         result;
  logic [IDX_W-1:0]          idx;
  logic [N_PORTS*DATA_W-1:0] data_r;

  assign req = bus.mem_read | bus.mem_write;

  multiport_ram_rr_arbiter #(.N(N_PORTS), .PTR_W(PTR_W)) u_arb (
    .req   (req),
    .ptr   (rr_ptr_r),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign in_range = (addr_r < ADDR_W'(SIZE));
  assign idx      = addr_r[IDX_W-1:0];
  assign access   = en && (state_r == ST_BUSY) && (cnt_r == 4'd0);
  assign sc_hit   = resv_valid_r[grant_r] && (resv_addr_r[grant_r] == addr_r) && in_range;
  assign do_write = access && in_range && ((op_r == OP_WRITE) || ((op_r == OP_SC) && sc_hit));

  // Value returned to the granted port in its ack cycle.
  always_comb begin
    result = '0;
    case (op_r)
      OP_READ, OP_LR: result = in_range ? mem[idx] : '0;
      OP_SC:          result = sc_hit ? DATA_W'(SC_OK) : DATA_W'(SC_FAIL);
      default:        result = '0;
    endcase
  end

  // One-cycle ack to the granted port; other ports keep their last read data.
  always_comb begin
    ack    = '0;
    data_r = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      ack[p] = access && (grant_r == PTR_W'(p));
      data_r[p*DATA_W +: DATA_W] = ack[p] ? result : hold_r[p];
    end
  end

  assign bus.mem_data_r = data_r;
  assign bus.mem_wait   = req & ~ack;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next state: grant from IDLE, return to IDLE on the access cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en && arb_valid) state_n = ST_BUSY;
        else                 state_n = state_r;
      end
      ST_BUSY: begin
        if (access) state_n = ST_IDLE;
        else        state_n = state_r;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Latch the granted request, run the wait counter, advance the RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 4'd0;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      op_r     <= OP_READ;
    end else if (en) begin
      if ((state_r == ST_IDLE) && arb_valid) begin
        grant_r <= arb_idx;
        addr_r  <= bus.mem_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        wdata_r <= bus.mem_data_w[int'(arb_idx)*DATA_W +: DATA_W];
        op_r    <= decode_op(bus.mem_read[arb_idx], bus.mem_write[arb_idx],
                             bus.mem_atomic[arb_idx]);
        cnt_r   <= 4'(LATENCY);
      end else if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else if (access) begin
        rr_ptr_r <= (grant_r == PTR_W'(N_PORTS - 1)) ? '0 : grant_r + PTR_W'(1);
      end
    end
  end

  // Reservations: writes kill matching entries, LR sets and SC clears the owner's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid_r <= '0;
      for (int q = 0; q < N_PORTS; q++) resv_addr_r[q] <= '0;
    end else if (access) begin
      for (int q = 0; q < N_PORTS; q++) begin
        if (do_write && (resv_addr_r[q] == addr_r)) resv_valid_r[q] <= 1'b0;
        if (grant_r == PTR_W'(q)) begin
          if ((op_r == OP_LR) && in_range) begin
            resv_valid_r[q] <= 1'b1;
            resv_addr_r[q]  <= addr_r;
          end else if (op_r == OP_SC) begin
            resv_valid_r[q] <= 1'b0;
          end
        end
      end
    end
  end

  // Remember the last value handed to each port so it holds between acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_PORTS; p++) hold_r[p] <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (ack[p]) hold_r[p] <= result;
      end
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= wdata_r;
  end

endmodule

// File: tb/tb_multiport_ram.sv
// Directed, table-driven bench for multiport_ram (2 ports, LATENCY=1).
module tb_multiport_ram;

  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SZ = 1024;
  localparam int LAT = 1;

  logic clk;
  logic rst_n;
  logic en;
  int   n_vec = 0;
  int   n_bad = 0;

  multiport_ram_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  multiport_ram #(.DATA_W(DW), .ADDR_W(AW), .SIZE(SZ), .N_PORTS(N), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        rd;
    logic        wr;
    logic        at;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic at,
                          input logic [31:0] a, input logic [31:0] d);
    bus.mem_read[p]            = rd;
    bus.mem_write[p]           = wr;
    bus.mem_atomic[p]          = at;
    bus.mem_addr[p*AW +: AW]   = a;
    bus.mem_data_w[p*DW +: DW] = d;
  endtask

  // Issue one request on port p and wait for its ack (bounded).
  task automatic do_access(input int p, input logic rd, input logic wr, input logic at,
                           input logic [31:0] a, input logic [31:0] d,
                           output int ack_c, output logic [31:0] rdat);
    set_port(p, rd, wr, at, a, d);
    ack_c = -1;
    rdat  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.mem_wait[p]) begin
        ack_c = c;
        rdat  = bus.mem_data_r[p*DW +: DW];
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    set_port(p, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Both ports write at the same cycle; report the cycle each one is acked in.
  task automatic pair(input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1,
                      output int ack0, output int ack1);
    logic act0, act1, done0, done1;
    set_port(0, 1'b0, 1'b1, 1'b0, a0, d0);
    set_port(1, 1'b0, 1'b1, 1'b0, a1, d1);
    act0 = 1'b1; act1 = 1'b1; ack0 = -1; ack1 = -1;
    for (int c = 0; c < 40; c++) begin
      if (!act0 && !act1) break;
      @(negedge clk);
      done0 = act0 && !bus.mem_wait[0];
      done1 = act1 && !bus.mem_wait[1];
      if (done0) ack0 = c;
      if (done1) ack1 = c;
      @(posedge clk);
      #1;
      if (done0) begin set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0); act0 = 1'b0; end
      if (done1) begin set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0); act1 = 1'b0; end
    end
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic add(input int p, input logic rd, input logic wr, input logic at,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e, input logic c);
    vec_t v;
    v.port = p; v.rd = rd; v.wr = wr; v.at = at;
    v.addr = a; v.wdata = d; v.exp = e; v.chk = c;
    vecs.push_back(v);
  endtask

  initial begin
    int          ack_c, a0, a1;
    logic [31:0] rdat;

    // port, rd, wr, at, addr, wdata, expected, check data
    add(0, 1'b0, 1'b1, 1'b0, 32'd100,  32'd1,      32'd0,      1'b0);
    add(0, 1'b1, 1'b0, 1'b0, 32'd100,  32'd0,      32'd1,      1'b1);
    add(0, 1'b0, 1'b1, 1'b0, 32'd200,  32'd4,      32'd0,      1'b0);
    add(0, 1'b1, 1'b0, 1'b1, 32'd200,  32'd0,      32'd4,      1'b1);
    add(0, 1'b0, 1'b1, 1'b1, 32'd200,  32'd8,      32'd0,      1'b1);
    add(0, 1'b1, 1'b0, 1'b0, 32'd200,  32'd0,      32'd8,      1'b1);
    add(0, 1'b0, 1'b1, 1'b1, 32'd200,  32'd9,      32'd1,      1'b1);
    add(0, 1'b1, 1'b0, 1'b0, 32'd200,  32'd0,      32'd8,      1'b1);
    add(0, 1'b1, 1'b0, 1'b1, 32'd300,  32'd0,      32'd0,      1'b0);
    add(1, 1'b0, 1'b1, 1'b0, 32'd300,  32'h55,     32'd0,      1'b0);
    add(0, 1'b0, 1'b1, 1'b1, 32'd300,  32'h77,     32'd1,      1'b1);
    add(1, 1'b1, 1'b0, 1'b0, 32'd300,  32'd0,      32'h55,     1'b1);
    add(0, 1'b0, 1'b1, 1'b0, 32'd400,  32'd0,      32'd0,      1'b0);
    add(0, 1'b1, 1'b0, 1'b1, 32'd400,  32'd0,      32'd0,      1'b1);
    add(0, 1'b0, 1'b1, 1'b0, 32'd400,  32'd3,      32'd0,      1'b0);
    add(0, 1'b0, 1'b1, 1'b1, 32'd400,  32'd4,      32'd1,      1'b1);
    add(0, 1'b1, 1'b0, 1'b0, 32'd400,  32'd0,      32'd3,      1'b1);
    add(0, 1'b1, 1'b0, 1'b0, 32'd1027, 32'd0,      32'd0,      1'b1);
    add(0, 1'b0, 1'b1, 1'b0, 32'd0,    32'h1234,   32'd0,      1'b0);
    add(0, 1'b0, 1'b1, 1'b0, 32'd1024, 32'hdead,   32'd0,      1'b0);
    add(0, 1'b1, 1'b0, 1'b0, 32'd0,    32'd0,      32'h1234,   1'b1);
    add(1, 1'b1, 1'b0, 1'b1, 32'd0,    32'd0,      32'h1234,   1'b1);
    add(1, 1'b0, 1'b1, 1'b1, 32'd1024, 32'd5,      32'd1,      1'b1);
    add(1, 1'b0, 1'b1, 1'b1, 32'd0,    32'd6,      32'd1,      1'b1);
    add(1, 1'b1, 1'b0, 1'b0, 32'd0,    32'd0,      32'h1234,   1'b1);

    rst_n = 1'b0;
    en    = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset data_r", bus.mem_data_r[31:0] | bus.mem_data_r[63:32], 32'd0);
    chk("reset wait", {30'd0, bus.mem_wait}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Simultaneous writes from reset: port0 first, port1 LATENCY+2 later.
    pair(32'd5, 32'hA, 32'd6, 32'hB, a0, a1);
    chk("pair1 ack0 cycle", a0, LAT + 1);
    chk("pair1 ack1 cycle", a1, 2 * LAT + 3);
    do_access(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, ack_c, rdat);
    chk("pair1 data5", rdat, 32'hA);
    // Last winner was port0, so the next simultaneous pair starts at port1.
    pair(32'd5, 32'hC, 32'd6, 32'hD, a0, a1);
    chk("pair2 ack1 cycle", a1, LAT + 1);
    chk("pair2 ack0 cycle", a0, 2 * LAT + 3);
    do_access(1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0, ack_c, rdat);
    chk("pair2 data6", rdat, 32'hD);

    foreach (vecs[i]) begin
      do_access(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].at,
                vecs[i].addr, vecs[i].wdata, ack_c, rdat);
      chk($sformatf("vec%0d latency", i), ack_c, LAT + 1);
      if (vecs[i].chk) chk($sformatf("vec%0d data", i), rdat, vecs[i].exp);
    end

    // Reset during BUSY of a write: no write lands, reservation is lost.
    do_access(0, 1'b0, 1'b1, 1'b0, 32'd7, 32'h11, ack_c, rdat);
    do_access(0, 1'b1, 1'b0, 1'b1, 32'd7, 32'd0, ack_c, rdat);
    chk("pre-reset LR 7", rdat, 32'h11);
    set_port(0, 1'b0, 1'b1, 1'b0, 32'd7, 32'h99);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wait in reset", {31'd0, bus.mem_wait[0]}, 32'd1);
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("wait drops with req", {31'd0, bus.mem_wait[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_access(0, 1'b0, 1'b1, 1'b1, 32'd7, 32'h22, ack_c, rdat);
    chk("SC after reset", rdat, 32'd1);
    do_access(0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, ack_c, rdat);
    chk("addr7 untouched", rdat, 32'h11);

    // en low for 5 cycles during BUSY delays the ack by exactly 5 cycles.
    set_port(0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd0);
    ack_c = -1;
    rdat  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.mem_wait[0]) begin
        ack_c = c;
        rdat  = bus.mem_data_r[31:0];
        break;
      end
      @(posedge clk);
      #1;
      if (c == 0) en = 1'b0;
      if (c == 5) en = 1'b1;
    end
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    en = 1'b1;
    chk("en stall ack cycle", ack_c, LAT + 1 + 5);
    chk("en stall data", rdat, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
